// File: rtl/dram_pkg.sv
// Shared types and constants for the DRAM command issuer: command and state
// enums, request op codes, address field widths and default timings.
package dram_pkg;

    localparam int ADDR_W    = 33;
    localparam int ROW_W     = 15;
    localparam int COL_W     = 8;
    localparam int BA_W      = 2;
    localparam int BG_W      = 2;
    localparam int BANK_W    = BG_W + BA_W;
    localparam int NUM_BANKS = 1 << BANK_W;
    localparam int CNT_W     = 16;

    localparam int DEF_T_RCD   = 24;
    localparam int DEF_T_RP    = 24;
    localparam int DEF_T_CL    = 24;
    localparam int DEF_T_CWL   = 20;
    localparam int DEF_T_BURST = 4;
    localparam int DEF_T_REFI  = 7800;
    localparam int DEF_T_RFC   = 350;

    localparam logic [1:0] OP_RD  = 2'd0;
    localparam logic [1:0] OP_WR  = 2'd1;
    localparam logic [1:0] OP_IF  = 2'd2;
    localparam logic [1:0] OP_ILL = 2'd3;

    typedef enum logic [2:0] {
        CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_PREA, CMD_REF
    } cmd_e;

    typedef enum logic [3:0] {
        ST_IDLE, ST_PRE, ST_WAIT_RP, ST_ACT, ST_WAIT_RCD, ST_CAS, ST_WAIT_DATA,
        ST_REF_PREA, ST_REF_WAIT_RP, ST_REF, ST_REF_WAIT_RFC
    } state_e;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic [BA_W-1:0]  ba;
        logic [BG_W-1:0]  bg;
    } dram_loc_t;

    // Byte-offset bits [5:0] never reach the DRAM, so callers pass [32:6].
    function automatic dram_loc_t decode(input logic [ADDR_W-1:6] a);
        dram_loc_t l;
        l.row = a[32:18];
        l.col = a[17:10];
        l.ba  = a[9:8];
        l.bg  = a[7:6];
        return l;
    endfunction

    function automatic logic [CNT_W-1:0] eff_t(input int t);
        return (t <= 0) ? CNT_W'(1) : CNT_W'(t);
    endfunction

endpackage

// File: rtl/dram_bank_table.sv
// Per-bank open flag and open-row register file, indexed by {bg,ba}.
module dram_bank_table
    import dram_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [BANK_W-1:0] lkp_idx_i,
    output logic              lkp_open_o,
    output logic [ROW_W-1:0]  lkp_row_o,
    input  logic              open_i,
    input  logic [BANK_W-1:0] open_idx_i,
    input  logic [ROW_W-1:0]  open_row_i,
    input  logic              close_i,
    input  logic [BANK_W-1:0] close_idx_i,
    input  logic              close_all_i,
    output logic              any_open_o
);

    logic [NUM_BANKS-1:0]            open_q, open_d;
    logic [NUM_BANKS-1:0][ROW_W-1:0] row_q, row_d;

    always_comb begin
        open_d = open_q;
        row_d  = row_q;
        if (close_all_i) begin
            open_d = '0;
        end else begin
            if (close_i) open_d[close_idx_i] = 1'b0;
            if (open_i) begin
                open_d[open_idx_i] = 1'b1;
                row_d[open_idx_i]  = open_row_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            open_q <= '0;
            row_q  <= '0;
        end else begin
            open_q <= open_d;
            row_q  <= row_d;
        end
    end

    assign lkp_open_o = open_q[lkp_idx_i];
    assign lkp_row_o  = row_q[lkp_idx_i];
    assign any_open_o = |open_q;

endmodule

// File: rtl/dram_cmd_issuer.sv
// Single-request DRAM command issuer with open-page policy.
// Define DRAM_REFRESH_EN to enable periodic PREA/REF refresh.
module dram_cmd_issuer
    import dram_pkg::*;
#(
    parameter int T_RCD   = DEF_T_RCD,
    parameter int T_RP    = DEF_T_RP,
    parameter int T_CL    = DEF_T_CL,
    parameter int T_CWL   = DEF_T_CWL,
    parameter int T_BURST = DEF_T_BURST,
    parameter int T_REFI  = DEF_T_REFI,
    parameter int T_RFC   = DEF_T_RFC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              cmd_valid,
    output logic [2:0]        cmd_type,
    output logic [BG_W-1:0]   cmd_bg,
    output logic [BA_W-1:0]   cmd_ba,
    output logic [ROW_W-1:0]  cmd_row,
    output logic [COL_W-1:0]  cmd_col,
    output logic              resp_valid,
    output logic [1:0]        resp_op,
    output logic [ADDR_W-1:0] resp_addr
);

    localparam logic [CNT_W-1:0] TRCD   = eff_t(T_RCD);
    localparam logic [CNT_W-1:0] TRP    = eff_t(T_RP);
    localparam logic [CNT_W-1:0] TRFC   = eff_t(T_RFC);
    localparam logic [CNT_W-1:0] LAT_RD = eff_t(T_CL) + eff_t(T_BURST);
    localparam logic [CNT_W-1:0] LAT_WR = eff_t(T_CWL) + eff_t(T_BURST);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    dram_loc_t         req_loc, cur_loc;
    logic              lkp_open, any_open;
    logic [ROW_W-1:0]  lkp_row;
    logic              ref_due, ref_done;

    assign req_loc  = decode(req_addr[ADDR_W-1:6]);
    assign cur_loc  = decode(addr_q[ADDR_W-1:6]);
    assign ref_done = (state_q == ST_REF_WAIT_RFC) && (cnt_q == CNT_W'(1));
    assign req_ready = !rst && (state_q == ST_IDLE) && !ref_due;

    dram_bank_table u_banks (
        .clk         (clk),
        .rst         (rst),
        .lkp_idx_i   ({req_loc.bg, req_loc.ba}),
        .lkp_open_o  (lkp_open),
        .lkp_row_o   (lkp_row),
        .open_i      (state_q == ST_ACT),
        .open_idx_i  ({cur_loc.bg, cur_loc.ba}),
        .open_row_i  (cur_loc.row),
        .close_i     (state_q == ST_PRE),
        .close_idx_i ({cur_loc.bg, cur_loc.ba}),
        .close_all_i (ref_done),
        .any_open_o  (any_open)
    );

`ifdef DRAM_REFRESH_EN
    localparam logic [31:0] REFI = 32'(T_REFI);
    logic [31:0] refcnt_q, refcnt_d;
    logic        ref_pend_q;

    assign refcnt_d = (refcnt_q == '0) ? REFI : refcnt_q - 32'd1;

    // A new expiry wins over the clear so a refresh is never silently dropped
    // on the same edge it completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refcnt_q   <= REFI;
            ref_pend_q <= 1'b0;
        end else begin
            refcnt_q <= refcnt_d;
            if (refcnt_q == '0)  ref_pend_q <= 1'b1;
            else if (ref_done)   ref_pend_q <= 1'b0;
        end
    end

    assign ref_due = ref_pend_q || (refcnt_q == '0);
`else
    logic unused_refi;
    assign unused_refi = (T_REFI != 0);
    assign ref_due     = 1'b0;
`endif

    // Issue states register their command on the edge they are left; waits
    // load T-1 so the next issue state runs exactly T edges later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            addr_q     <= '0;
            cmd_valid  <= 1'b0;
            cmd_type   <= CMD_NOP;
            cmd_bg     <= '0;
            cmd_ba     <= '0;
            cmd_row    <= '0;
            cmd_col    <= '0;
            resp_valid <= 1'b0;
            resp_op    <= '0;
            resp_addr  <= '0;
        end else begin
            cmd_valid  <= 1'b0;
            resp_valid <= 1'b0;
            if (state_q inside {ST_PRE, ST_ACT, ST_CAS}) begin
                cmd_valid <= 1'b1;
                cmd_bg    <= cur_loc.bg;
                cmd_ba    <= cur_loc.ba;
                cmd_row   <= cur_loc.row;
                cmd_col   <= cur_loc.col;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (ref_due) begin
                        state_q <= any_open ? ST_REF_PREA : ST_REF;
                    end else if (req_valid) begin
                        op_q   <= req_op;
                        addr_q <= req_addr;
                        if (req_op == OP_ILL) begin
                            cnt_q   <= CNT_W'(1);
                            state_q <= ST_WAIT_DATA;
                        end else if (lkp_open && lkp_row == req_loc.row) begin
                            state_q <= ST_CAS;
                        end else if (lkp_open) begin
                            state_q <= ST_PRE;
                        end else begin
                            state_q <= ST_ACT;
                        end
                    end
                end
                ST_PRE: begin
                    cmd_type <= CMD_PRE;
                    cnt_q    <= TRP - CNT_W'(1);
                    state_q  <= (TRP == CNT_W'(1)) ? ST_ACT : ST_WAIT_RP;
                end
                ST_WAIT_RP: begin
                    if (cnt_q == CNT_W'(1)) state_q <= ST_ACT;
                    else                    cnt_q   <= cnt_q - CNT_W'(1);
                end
                ST_ACT: begin
                    cmd_type <= CMD_ACT;
                    cnt_q    <= TRCD - CNT_W'(1);
                    state_q  <= (TRCD == CNT_W'(1)) ? ST_CAS : ST_WAIT_RCD;
                end
                ST_WAIT_RCD: begin
                    if (cnt_q == CNT_W'(1)) state_q <= ST_CAS;
                    else                    cnt_q   <= cnt_q - CNT_W'(1);
                end
                ST_CAS: begin
                    cmd_type <= (op_q == OP_WR) ? CMD_WR : CMD_RD;
                    cnt_q    <= (op_q == OP_WR) ? LAT_WR : LAT_RD;
                    state_q  <= ST_WAIT_DATA;
                end
                ST_WAIT_DATA: begin
                    if (cnt_q == CNT_W'(1)) begin
                        resp_valid <= 1'b1;
                        resp_op    <= op_q;
                        resp_addr  <= addr_q;
                        state_q    <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_REF_PREA: begin
                    cmd_valid <= 1'b1;
                    cmd_type  <= CMD_PREA;
                    cnt_q     <= TRP - CNT_W'(1);
                    state_q   <= (TRP == CNT_W'(1)) ? ST_REF : ST_REF_WAIT_RP;
                end
                ST_REF_WAIT_RP: begin
                    if (cnt_q == CNT_W'(1)) state_q <= ST_REF;
                    else                    cnt_q   <= cnt_q - CNT_W'(1);
                end
                ST_REF: begin
                    cmd_valid <= 1'b1;
                    cmd_type  <= CMD_REF;
                    cnt_q     <= TRFC;
                    state_q   <= ST_REF_WAIT_RFC;
                end
                ST_REF_WAIT_RFC: begin
                    if (cnt_q == CNT_W'(1)) state_q <= ST_IDLE;
                    else                    cnt_q   <= cnt_q - CNT_W'(1);
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
